// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_tx scheduler
package uart_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  localparam logic [3:0] HDR_NIBBLE = 4'hA;
  localparam int BYTES_PER_WORD = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_grant+1
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last_grant,
  output logic         grant_valid,
  output logic [1:0]   grant_id
);
  logic [3:0] req_w;
  logic [1:0] k;
  assign req_w = 4'(req);
  always_comb begin
    grant_valid = 1'b0;
    grant_id = '0;
    k = '0;
    for (int i = 1; i <= N; i++) begin
      k = 2'((int'(last_grant) + i) % N);
      if (!grant_valid && req_w[k]) begin
        grant_valid = 1'b1;
        grant_id = k;
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin framing of 64-bit words from N_REQ requesters onto one uart_tx
module uart_tx_scheduler import uart_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int HEADER_EN = 1,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [64*N_REQ-1:0] data_64_bus,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [1:0]         cur_id,
  output logic               tx_enable,
  output logic [7:0]         uart_data_in,
  input  logic               tx_done,
  output logic               frame_done,
  output logic               timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [3:0] LAST = 4'(BYTES_PER_WORD - 1 + HEADER_EN);
  state_t state, state_n;
  logic [1:0] last_grant, last_n, cur_n, grant_id;
  logic [3:0] byte_idx, idx_n, rem;
  logic [CW-1:0] cnt, cnt_n;
  logic [63:0] word, word_n;
  logic [7:0] data_n, byte_sel;
  logic [N_REQ-1:0] ack_n;
  logic grant_valid, en_n, fd_n, to_n;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req),
    .last_grant(last_grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id)
  );
  assign busy = state != IDLE;
  // rem counts bytes left after this one; the word is sent MSB byte first
  assign rem = LAST - byte_idx;
  assign byte_sel = (HEADER_EN != 0 && byte_idx == 4'd0) ? {HDR_NIBBLE, 2'b00, cur_id}
                                                         : 8'(word >> {rem, 3'b000});
  always_comb begin
    state_n = state;
    last_n = last_grant;
    cur_n = cur_id;
    idx_n = byte_idx;
    cnt_n = cnt;
    word_n = word;
    data_n = uart_data_in;
    ack_n = '0;
    en_n = 1'b0;
    fd_n = 1'b0;
    to_n = 1'b0;
    case (state)
      IDLE: if (grant_valid) begin
        state_n = SEND;
        last_n = grant_id;
        cur_n = grant_id;
        idx_n = '0;
        word_n = 64'(data_64_bus >> {grant_id, 6'b0});
        ack_n = N_REQ'(1) << grant_id;
      end
      SEND: begin
        state_n = WAIT;
        data_n = byte_sel;
        en_n = 1'b1;
        cnt_n = '0;
      end
      WAIT: if (tx_done) begin
        state_n = byte_idx == LAST ? IDLE : SEND;
        fd_n = byte_idx == LAST;
        idx_n = byte_idx == LAST ? byte_idx : byte_idx + 4'd1;
      end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
        state_n = IDLE;
        to_n = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 2'(N_REQ - 1);
      cur_id <= '0;
      byte_idx <= '0;
      cnt <= '0;
      word <= '0;
      uart_data_in <= '0;
      ack <= '0;
      tx_enable <= 1'b0;
      frame_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      last_grant <= last_n;
      cur_id <= cur_n;
      byte_idx <= idx_n;
      cnt <= cnt_n;
      word <= word_n;
      uart_data_in <= data_n;
      ack <= ack_n;
      tx_enable <= en_n;
      frame_done <= fd_n;
      timeout_err <= to_n;
    end
  end
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one uart_tx (range 2..4).
REQ-002 Parameter HEADER_EN, default 1, SHALL prepend one header byte to each frame when 1.
REQ-003 Parameter TIMEOUT_CYC, default 20000, SHALL set the maximum clk cycles to wait for tx_done per byte.
REQ-004 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  N_REQ  per-requester level request to send one 64-bit word.
REQ-007 data_64_bus  input  64*N_REQ  word of requester i on bits [64*i+63:64*i].
REQ-008 ack  output  N_REQ  one-cycle pulse: the granted word was latched, and the requester may change its data.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 cur_id  output  2  index of the current or last granted requester.
REQ-011 tx_enable  output  1  one-cycle start pulse to uart_tx.
REQ-012 uart_data_in  output  8  byte presented to uart_tx.
REQ-013 tx_done  input  1  one-cycle completion pulse from uart_tx.
REQ-014 frame_done  output  1  one-cycle pulse after the last byte of a frame completes.
REQ-015 timeout_err  output  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-016 The scheduler SHALL use states IDLE, SEND and WAIT.
REQ-017 IDLE with any req bit high SHALL select a winner by round robin, searching from (last_grant+1) mod N_REQ upward.
- The grant SHALL latch that requester's word, pulse ack[winner], update cur_id and last_grant, clear byte_idx and enter SEND.
- All of this SHALL happen in the same cycle.
REQ-018 Request bits with an index at or above N_REQ do not exist; when no req bit is high, IDLE SHALL hold.
REQ-019 Frame byte order SHALL be as follows.
- With HEADER_EN=1: header {4'hA, 2'b00, id}, then the latched word MSB byte first ([63:56] … [7:0]), 9 bytes in total.
- With HEADER_EN=0: the latched word only, MSB byte first, 8 bytes in total.
REQ-020 SEND SHALL drive uart_data_in with byte[byte_idx], assert tx_enable for exactly one cycle, clear the timeout counter and enter WAIT.
REQ-021 uart_data_in SHALL hold stable from SEND until the next byte is selected.
REQ-022 On tx_done in WAIT:
- if byte_idx is the last index, frame_done SHALL pulse and the state SHALL return to IDLE;
- otherwise byte_idx SHALL increment and the state SHALL enter SEND.
REQ-023 The latency from tx_done to the next tx_enable SHALL be exactly 2 cycles.
REQ-024 The timeout counter SHALL increment every WAIT cycle; when it reaches TIMEOUT_CYC-1 without tx_done:
- timeout_err SHALL pulse;
- the rest of the frame SHALL be discarded;
- the state SHALL return to IDLE with last_grant unchanged, so the arbiter advances past that requester.
REQ-025 tx_done outside WAIT SHALL be ignored.
REQ-026 tx_done arriving in the same cycle as timeout expiry SHALL be treated as completion, with no timeout_err.
REQ-027 A req that deasserts after ack SHALL NOT affect the frame in flight; a req still high after its frame SHALL be re-arbitrated fairly.
REQ-028 The timeout counter width SHALL be $clog2(TIMEOUT_CYC) and SHALL NOT wrap within WAIT.

Reset
REQ-029 While rst_n is low, the block SHALL force:
- state=IDLE, last_grant=N_REQ-1, cur_id=0, byte_idx=0, counter=0;
- uart_data_in=8'h00;
- ack, busy, tx_enable, frame_done and timeout_err all 0.
REQ-030 A reset asserted mid-frame SHALL abort the frame immediately with no frame_done or timeout_err pulse, and the first grant after release SHALL go to requester 0.

Structure
REQ-031 A shared package uart_pkg SHALL hold:
- the state enum;
- HDR_NIBBLE=4'hA;
- BYTES_PER_WORD=8.
REQ-032 Round-robin selection SHALL be one sub-module, rr_arbiter (req, last_grant -> grant_valid, grant_id), which is purely combinational.

Verification
REQ-033 After reset, req=4'b0001 with word0=64'h0123456789ABCDEF and HEADER_EN=1 -> ack[0] pulses, bytes are A0 01 23 45 67 89 AB CD EF, then one frame_done pulse.
REQ-034 req=4'b1111 held through 8 frames -> grant order is 0,1,2,3,0,1,2,3 and each ack is a single-cycle pulse.
REQ-035 A uart_tx model returning tx_done 5 cycles after each tx_enable -> the tx_enable spacing is 7 cycles.
REQ-036 tx_done is suppressed on byte 3 with TIMEOUT_CYC=100 -> timeout_err pulses 100 cycles after that tx_enable, there is no frame_done, and the next grant goes to the next requester.
REQ-037 rst_n is pulsed low during byte 5 of requester 2's frame -> all outputs reach their reset values asynchronously, and with req=4'b1111 held the first grant after release is requester 0.
REQ-038 HEADER_EN=0 with word=64'hFFFF_0000_AAAA_5555 -> exactly 8 tx_enable pulses with bytes FF FF 00 00 AA AA 55 55.
